// File: rtl/router_config_ctrl.sv
// router_config_ctrl: buffers route requests and applies them to the router with a setup/pulse/hold
// update strobe, ordering per-output activation around each reroute.  Rev 1.0
`default_nettype none

module router_config_ctrl #(
   parameter int   W_SEL     = 4,
   parameter int   N_OUT     = 8,
   parameter int   DEPTH     = 4,
   parameter int   T_SETUP   = 2,
   parameter int   T_PULSE   = 2,
   parameter int   T_HOLD    = 2,
   parameter logic ACTV_INIT = 1'b1
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               req_valid_in,
   output logic               req_ready_out,
   input  logic [W_SEL-1:0]   req_src_in,
   input  logic [W_SEL-1:0]   req_dest_in,
   input  logic               req_actv_in,
   output logic [W_SEL-1:0]   src_select_out,
   output logic [W_SEL-1:0]   dest_select_out,
   output logic               update_out,
   output logic [N_OUT-1:0]   output_active_out,
   output logic               busy_out,
   output logic               err_out,
   input  logic [W_SEL-1:0]   rd_dest_in,
   output logic [W_SEL-1:0]   rd_src_out
);

   localparam int c_AW    = $clog2(DEPTH);
   localparam int c_IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int c_EW    = 2 * W_SEL + 1;
   localparam int c_T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                                : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
   localparam int c_CNT_W = (c_T_MAX > 1) ? $clog2(c_T_MAX) : 1;
   localparam logic [c_CNT_W-1:0] c_SETUP_M1 = c_CNT_W'(T_SETUP - 1);
   localparam logic [c_CNT_W-1:0] c_PULSE_M1 = c_CNT_W'(T_PULSE - 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_M1  = c_CNT_W'(T_HOLD - 1);
   localparam logic [W_SEL:0]     c_N_OUT    = (W_SEL + 1)'(N_OUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_PULSE = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // FIFO entries are packed {actv, dest, src}
   logic [c_EW-1:0]    fifo_q [DEPTH];
   logic [c_AW:0]      wr_ptr_q, rd_ptr_q;
   logic               w_full, w_empty, w_push, w_pop;
   logic [c_EW-1:0]    w_head;
   logic [W_SEL-1:0]   w_head_src, w_head_dest;
   logic               w_head_actv, w_head_ok;

   state_t             state_q, state_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic [W_SEL-1:0]   src_q, src_d, dest_q, dest_d;
   logic               actv_q, actv_d, upd_q, upd_d, err_q, err_d;
   logic [N_OUT-1:0]   active_q, active_d;
   logic [W_SEL-1:0]   shadow_q [N_OUT];
   logic               w_sh_we;

   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                    (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
   assign w_push  = req_valid_in && !w_full;

   assign w_head      = fifo_q[rd_ptr_q[c_AW-1:0]];
   assign w_head_src  = w_head[W_SEL-1:0];
   assign w_head_dest = w_head[2*W_SEL-1:W_SEL];
   assign w_head_actv = w_head[2*W_SEL];
   assign w_head_ok   = ({1'b0, w_head_dest} < c_N_OUT);

   always_ff @(posedge clk_in) begin
      if (w_push) fifo_q[wr_ptr_q[c_AW-1:0]] <= {req_actv_in, req_dest_in, req_src_in};
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      src_d    = src_q;
      dest_d   = dest_q;
      actv_d   = actv_q;
      upd_d    = upd_q;
      err_d    = 1'b0;
      active_d = active_q;
      w_pop    = 1'b0;
      w_sh_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_head_ok) begin
                  state_d = S_SETUP;
                  cnt_d   = c_SETUP_M1;
                  src_d   = w_head_src;
                  dest_d  = w_head_dest;
                  actv_d  = w_head_actv;
                  // Take the output down before its select starts moving
                  if (!w_head_actv) active_d[w_head_dest[c_IDX_W-1:0]] = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_PULSE;
               cnt_d   = c_PULSE_M1;
               upd_d   = 1'b1;
               w_sh_we = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               cnt_d   = c_HOLD_M1;
               upd_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               if (actv_q) active_d[dest_q[c_IDX_W-1:0]] = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         src_q    <= '0;
         dest_q   <= '0;
         actv_q   <= 1'b0;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
         active_q <= {N_OUT{ACTV_INIT}};
         for (int i = 0; i < N_OUT; i++) shadow_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         src_q    <= src_d;
         dest_q   <= dest_d;
         actv_q   <= actv_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
         active_q <= active_d;
         if (w_sh_we) shadow_q[dest_q[c_IDX_W-1:0]] <= src_q;
      end
   end

   assign req_ready_out     = !w_full;
   assign src_select_out    = src_q;
   assign dest_select_out   = dest_q;
   assign update_out        = upd_q;
   assign output_active_out = active_q;
   assign err_out           = err_q;
   assign busy_out          = (state_q != S_IDLE) || !w_empty;
   assign rd_src_out        = ({1'b0, rd_dest_in} < c_N_OUT) ? shadow_q[rd_dest_in[c_IDX_W-1:0]] : '0;

endmodule

`default_nettype wire

// File: tb/tb_router_config_ctrl.sv
// tb_router_config_ctrl: directed self-checking bench for router_config_ctrl (default parameters).
// Rev 1.0
`default_nettype none

module tb_router_config_ctrl;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       req_valid_in = 1'b0;
   logic       req_ready_out;
   logic [3:0] req_src_in = '0;
   logic [3:0] req_dest_in = '0;
   logic       req_actv_in = 1'b0;
   logic [3:0] src_select_out, dest_select_out;
   logic       update_out;
   logic [7:0] output_active_out;
   logic       busy_out, err_out;
   logic [3:0] rd_dest_in = '0;
   logic [3:0] rd_src_out;

   int n_tests = 0;
   int n_fail  = 0;

   router_config_ctrl dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .req_valid_in      (req_valid_in),
      .req_ready_out     (req_ready_out),
      .req_src_in        (req_src_in),
      .req_dest_in       (req_dest_in),
      .req_actv_in       (req_actv_in),
      .src_select_out    (src_select_out),
      .dest_select_out   (dest_select_out),
      .update_out        (update_out),
      .output_active_out (output_active_out),
      .busy_out          (busy_out),
      .err_out           (err_out),
      .rd_dest_in        (rd_dest_in),
      .rd_src_out        (rd_src_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Presents one request for a single edge; returns with edge k just passed
   task automatic send(input logic [3:0] s, input logic [3:0] d, input logic a);
      n_tests++;
      if (req_ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready: got %b expected 1", req_ready_out);
      end
      req_valid_in = 1'b1;
      req_src_in   = s;
      req_dest_in  = d;
      req_actv_in  = a;
      tick();
      req_valid_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      #23;
      rst_in = 1'b0;
      rd_dest_in = 4'd5;
      tick();
      n_tests++;
      if ({src_select_out, dest_select_out, update_out, err_out, busy_out, req_ready_out} !== {8'h00, 4'b0001}) begin
         n_fail++;
         $display("FAIL reset_outs: got sel=%h/%h upd=%b err=%b busy=%b rdy=%b expected 0/0 0 0 0 1",
                  src_select_out, dest_select_out, update_out, err_out, busy_out, req_ready_out);
      end
      n_tests++;
      if (output_active_out !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_active: got %h expected ff", output_active_out);
      end
      n_tests++;
      if (rd_src_out !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_shadow: got %h expected 0", rd_src_out);
      end
   endtask

   task automatic test_single();
      send(4'd3, 4'd5, 1'b1);
      for (int e = 1; e <= 7; e++) begin
         tick();
         n_tests++;
         if (update_out !== (e == 3 || e == 4)) begin
            n_fail++;
            $display("FAIL single_update e%0d: got %b expected %b", e, update_out, (e == 3 || e == 4));
         end
         n_tests++;
         if (output_active_out[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_active5 e%0d: got %b expected 1", e, output_active_out[5]);
         end
         if (e == 1) begin
            n_tests++;
            if ({src_select_out, dest_select_out} !== 8'h35) begin
               n_fail++;
               $display("FAIL single_sel: got %h/%h expected 3/5", src_select_out, dest_select_out);
            end
         end
         if (e == 6 || e == 7) begin
            n_tests++;
            if (busy_out !== (e == 6)) begin
               n_fail++;
               $display("FAIL single_busy e%0d: got %b expected %b", e, busy_out, (e == 6));
            end
         end
      end
      rd_dest_in = 4'd5;
      #1;
      n_tests++;
      if (rd_src_out !== 4'd3) begin
         n_fail++;
         $display("FAIL single_shadow: got %h expected 3", rd_src_out);
      end
   endtask

   task automatic test_deactivate();
      send(4'd1, 4'd2, 1'b0);
      for (int e = 1; e <= 7; e++) begin
         tick();
         n_tests++;
         if (output_active_out !== 8'hFB) begin
            n_fail++;
            $display("FAIL deact_active e%0d: got %h expected fb", e, output_active_out);
         end
         if (e == 1 || e == 3) begin
            n_tests++;
            if (update_out !== (e == 3)) begin
               n_fail++;
               $display("FAIL deact_update e%0d: got %b expected %b", e, update_out, (e == 3));
            end
         end
      end
   endtask

   task automatic test_activate();
      send(4'd4, 4'd2, 1'b1);
      for (int e = 1; e <= 7; e++) begin
         tick();
         n_tests++;
         if (output_active_out !== ((e == 7) ? 8'hFF : 8'hFB)) begin
            n_fail++;
            $display("FAIL act_order e%0d: got %h expected %h", e, output_active_out, (e == 7) ? 8'hFF : 8'hFB);
         end
      end
      rd_dest_in = 4'd2;
      #1;
      n_tests++;
      if (rd_src_out !== 4'd4) begin
         n_fail++;
         $display("FAIL act_shadow: got %h expected 4", rd_src_out);
      end
   endtask

   // 8 requests (src=dest=i) with valid held; pops land at edges 1+7i, last HOLD exit at edge 56
   task automatic test_full();
      int acc = 0;
      int nup = 0;
      logic prev_upd = 1'b0;
      logic seen_low = 1'b0;
      logic w;
      for (int cyc = 0; cyc <= 62; cyc++) begin
         req_valid_in = (acc < 8);
         req_src_in   = 4'(acc);
         req_dest_in  = 4'(acc);
         req_actv_in  = 1'b1;
         w = req_valid_in && req_ready_out;
         tick();
         if (w) acc++;
         if (!req_ready_out && !seen_low) begin
            seen_low = 1'b1;
            n_tests++;
            if (acc != 5 || cyc != 4) begin
               n_fail++;
               $display("FAIL full_ready_low: got acc=%0d cyc=%0d expected acc=5 cyc=4", acc, cyc);
            end
         end
         if (update_out && !prev_upd) begin
            n_tests++;
            if (cyc != 3 + 7 * nup || src_select_out !== 4'(nup) || dest_select_out !== 4'(nup)) begin
               n_fail++;
               $display("FAIL full_order #%0d: got cyc=%0d sel=%h/%h expected cyc=%0d sel=%h/%h",
                        nup, cyc, src_select_out, dest_select_out, 3 + 7 * nup, 4'(nup), 4'(nup));
            end
            nup++;
         end
         prev_upd = update_out;
         n_tests++;
         if (busy_out !== (cyc < 56)) begin
            n_fail++;
            $display("FAIL full_busy cyc%0d: got %b expected %b", cyc, busy_out, (cyc < 56));
         end
      end
      req_valid_in = 1'b0;
      n_tests++;
      if (acc != 8 || nup != 8 || !seen_low) begin
         n_fail++;
         $display("FAIL full_count: got acc=%0d upd=%0d low=%b expected 8 8 1", acc, nup, seen_low);
      end
      n_tests++;
      if (output_active_out !== 8'hFF) begin
         n_fail++;
         $display("FAIL full_active: got %h expected ff", output_active_out);
      end
   endtask

   task automatic test_invalid();
      send(4'd9, 4'd9, 1'b0);
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_tests++;
         if (err_out !== (e == 1) || update_out !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_err e%0d: got err=%b upd=%b expected err=%b upd=0", e, err_out, update_out, (e == 1));
         end
      end
      n_tests++;
      if ({src_select_out, dest_select_out} !== 8'h77 || output_active_out !== 8'hFF || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_state: got sel=%h/%h act=%h busy=%b expected 7/7 ff 0",
                  src_select_out, dest_select_out, output_active_out, busy_out);
      end
      rd_dest_in = 4'd9;
      #1;
      n_tests++;
      if (rd_src_out !== 4'd0) begin
         n_fail++;
         $display("FAIL inv_rd_oob: got %h expected 0", rd_src_out);
      end
      rd_dest_in = 4'd7;
      #1;
      n_tests++;
      if (rd_src_out !== 4'd7) begin
         n_fail++;
         $display("FAIL inv_shadow: got %h expected 7", rd_src_out);
      end
      send(4'd6, 4'd1, 1'b1);
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 1 || e == 3 || e == 5) begin
            n_tests++;
            if (update_out !== (e == 3) || {src_select_out, dest_select_out} !== 8'h61) begin
               n_fail++;
               $display("FAIL inv_next e%0d: got upd=%b sel=%h/%h expected upd=%b sel=6/1",
                        e, update_out, src_select_out, dest_select_out, (e == 3));
            end
         end
      end
   endtask

   task automatic test_reset_pulse();
      send(4'd2, 4'd3, 1'b0);
      tick();
      tick();
      tick();
      n_tests++;
      if (update_out !== 1'b1 || output_active_out !== 8'hF7) begin
         n_fail++;
         $display("FAIL rp_pre: got upd=%b act=%h expected 1 f7", update_out, output_active_out);
      end
      #2;
      rst_in = 1'b1;
      #1;
      n_tests++;
      if (update_out !== 1'b0 || output_active_out !== 8'hFF || {src_select_out, dest_select_out} !== 8'h00
          || busy_out !== 1'b0 || req_ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL rp_async: got upd=%b act=%h sel=%h/%h busy=%b rdy=%b expected 0 ff 0/0 0 1",
                  update_out, output_active_out, src_select_out, dest_select_out, busy_out, req_ready_out);
      end
      rd_dest_in = 4'd1;
      #1;
      n_tests++;
      if (rd_src_out !== 4'd0) begin
         n_fail++;
         $display("FAIL rp_shadow_clr: got %h expected 0", rd_src_out);
      end
      #10;
      rst_in = 1'b0;
      tick();
      send(4'd5, 4'd3, 1'b1);
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 1 || e == 3 || e == 5 || e == 7) begin
            n_tests++;
            if (update_out !== (e == 3) || {src_select_out, dest_select_out} !== 8'h53 || busy_out !== (e != 7)) begin
               n_fail++;
               $display("FAIL rp_after e%0d: got upd=%b sel=%h/%h busy=%b expected upd=%b sel=5/3 busy=%b",
                        e, update_out, src_select_out, dest_select_out, busy_out, (e == 3), (e != 7));
            end
         end
      end
      rd_dest_in = 4'd3;
      #1;
      n_tests++;
      if (rd_src_out !== 4'd5) begin
         n_fail++;
         $display("FAIL rp_shadow: got %h expected 5", rd_src_out);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_deactivate();
      test_activate();
      test_full();
      test_invalid();
      test_reset_pulse();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/router_config_ctrl.md
# router_config_ctrl

Sequences source/destination route writes into the output router from a single clock domain. Route requests from the frontpanel controller are buffered, then applied one at a time with a setup/pulse/hold strobe on `update_out`, so the router's edge-triggered select register never sees selects changing around the update edge. The block also owns the router's per-output activation vector, ordered so an output is never enabled while its route is in transition. It sits between the frontpanel controller and the router.

## Interface
- `W_SEL`, 4, width of source/destination select
- `N_OUT`, 8, number of router output channels (≤ 2^W_SEL)
- `DEPTH`, 4, request FIFO depth (power of two, ≥ 2)
- `T_SETUP`, 2, cycles selects are stable before `update_out` rises (≥ 1)
- `T_PULSE`, 2, cycles `update_out` is high (≥ 1)
- `T_HOLD`, 2, cycles selects are held after `update_out` falls (≥ 1)
- `ACTV_INIT`, 1, reset value of every `output_active_out` bit

Ports:
- `clk_in` in 1: system clock. Single clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `req_valid_in` in 1: route request valid
- `req_ready_out` out 1: FIFO not full; a request is accepted on an edge where valid && ready
- `req_src_in` in W_SEL: source channel for request
- `req_dest_in` in W_SEL: destination output channel for request
- `req_actv_in` in 1: activation state for the destination after the route is applied
- `src_select_out` out W_SEL: to router `src_select_in`
- `dest_select_out` out W_SEL: to router `dest_select_in`
- `update_out` out 1: to router `update_in`
- `output_active_out` out N_OUT: to router `output_active_in`
- `busy_out` out 1: FSM not IDLE or FIFO non-empty
- `err_out` out 1: one-cycle pulse, request discarded (dest ≥ N_OUT)
- `rd_dest_in` in W_SEL: shadow readback address
- `rd_src_out` out W_SEL: combinational shadow route for `rd_dest_in`; 0 if out of range

## Operation
- Request FIFO: DEPTH entries of {src, dest, actv}. `req_ready_out` = !full, registered-state-derived, with no combinational path from `req_valid_in`. Push and pop on the same edge are allowed when neither full nor empty. When full, no push is accepted.
- FSM states are IDLE, SETUP, PULSE, and HOLD. One down-counter is shared across states, wide enough for max(T_*).
- **IDLE → SETUP**
  - Trigger: FIFO non-empty and the head dest < N_OUT.
  - Pop the head. Register `src_select_out`/`dest_select_out` from the entry and latch actv.
  - If actv = 0, clear `output_active_out[dest]` on the same edge (deactivate before rerouting).
- **IDLE, head dest ≥ N_OUT:** pop the head. Pulse `err_out` for one cycle. Stay in IDLE. No output changes.
- **SETUP → PULSE:** after T_SETUP cycles. `update_out` goes high on entry, and `shadow[dest]` ← src.
- **PULSE → HOLD:** after T_PULSE cycles. `update_out` goes low.
- **HOLD → IDLE:** after T_HOLD cycles. If actv = 1, set `output_active_out[dest]` on this edge (activate after the route is settled).
- `src_select_out`/`dest_select_out` change only on IDLE→SETUP edges. They hold their last value otherwise.
- Shadow table: N_OUT × W_SEL registers. It mirrors the router's select array.

## Timing
- Reset values:
  - `src_select_out` = 0, `dest_select_out` = 0, `update_out` = 0
  - `output_active_out` = {N_OUT{ACTV_INIT}}
  - `err_out` = 0, `busy_out` = 0, `req_ready_out` = 1
  - shadow all 0, FIFO empty, FSM in IDLE
- Request accepted at edge k into an empty FIFO with FSM in IDLE:
  - selects change at edge k+1
  - `update_out` high at edge k+1+T_SETUP
  - `update_out` low at edge k+1+T_SETUP+T_PULSE
  - activation set and FSM back in IDLE at edge k+1+T_SETUP+T_PULSE+T_HOLD
- Back-to-back requests: the next pop happens one cycle after returning to IDLE. Per-request period is 1+T_SETUP+T_PULSE+T_HOLD cycles.
- `err_out` asserts on the edge the invalid entry is popped (edge k+1 for an immediate request).
- Reset asserted mid-sequence: all outputs go to reset values immediately and asynchronously, including `update_out` → 0. Queued requests are lost.
- A request with a dest equal to the one currently sequencing is queued. It is applied after the current one completes.

## Test plan
- **Reset:** assert `rst_in` mid-clock → all outputs at reset values without waiting for a clock edge; `output_active_out` = 8'hFF with defaults.
- **Single request** src=3, dest=5, actv=1 at edge 0 → selects 3/5 at edge 1; `update_out` high edges 3–4, low at edge 5; `output_active_out[5]` stays 1 throughout; `rd_dest_in`=5 gives `rd_src_out`=3.
- **Deactivating request** dest=2, actv=0 → `output_active_out[2]` = 0 at edge 1, before `update_out` rises, and stays 0.
- **Activation ordering:** dest=2, actv=1 after a deactivation → bit 2 stays 0 until the HOLD exit edge, then becomes 1.
- **Full FIFO:** hold `req_valid_in` high for 8 requests → `req_ready_out` low after 4 entries plus one popped; all 8 applied in order, none dropped; `busy_out` low only after the last HOLD.
- **Invalid dest:** dest=9 (N_OUT=8) → one-cycle `err_out`, no `update_out` pulse, shadow and activation unchanged; the next valid request proceeds normally.
- **Reset during PULSE** → `update_out` drops immediately; after release, a new request sequences from IDLE correctly.
